// File: rtl/alu_oper_arbiter_pkg.sv
// alu_oper_arbiter_pkg: FSM state encoding, operand-B select codes and burst-length helper.
package alu_oper_arbiter_pkg;
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_CPU_OP    = 2'd1;
  localparam logic [1:0] ST_DMA_BURST = 2'd2;
  localparam logic [1:0] SEL_D0B   = 2'b00;
  localparam logic [1:0] SEL_SIMM  = 2'b01;
  localparam logic [1:0] SEL_ZIMM  = 2'b10;
  localparam logic [1:0] SEL_DESPL = 2'b11;
  function automatic logic [7:0] beats(input logic [7:0] len);
    return (len == 8'd0) ? 8'd1 : len;
  endfunction
endpackage

// File: rtl/dma_beat_counter.sv
// dma_beat_counter: loadable 8-bit down-counter flagging the final DMA beat.
module dma_beat_counter
  import alu_oper_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic [7:0] len_i,
  input  logic       dec_i,
  output logic       last_o
);
  logic [7:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? beats(len_i) : (dec_i && cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= reset ? 8'd0 : cnt_d;
  assign last_o = cnt_q == 8'd1;
endmodule

// File: rtl/alu_oper_arbiter.sv
// alu_oper_arbiter: CPU/DMA arbiter for the ALU operand-B path with DMA starvation guard.
module alu_oper_arbiter
  import alu_oper_arbiter_pkg::*;
#(
  parameter int         STARVE_LIMIT = 4,
  parameter logic [1:0] DMA_SEL      = SEL_ZIMM
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_req,
  input  logic [1:0] cpu_sel,
  input  logic       dma_req,
  input  logic [7:0] dma_len,
  output logic       cpu_gnt,
  output logic       dma_gnt,
  output logic [1:0] sel_OperaB,
  output logic       dma_done,
  output logic       busy
);
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  logic [1:0] state_q, state_d, sel_q, sel_d;
  logic [3:0] wait_q, wait_d;
  logic       last, arb, take_dma, take_cpu;
  always_comb begin
    arb      = state_q != ST_DMA_BURST || last;
    take_dma = arb && dma_req && (!cpu_req || wait_q == LIM);
    take_cpu = arb && cpu_req && !take_dma;
    state_d  = take_dma ? ST_DMA_BURST : take_cpu ? ST_CPU_OP : arb ? ST_IDLE : state_q;
    sel_d    = state_d == ST_DMA_BURST ? DMA_SEL : take_cpu ? cpu_sel : SEL_D0B;
    // a cycle counts as waiting only when DMA asked and was not granted next cycle
    wait_d   = (take_dma || !dma_req) ? 4'd0 :
               (state_d != ST_DMA_BURST && wait_q < LIM) ? wait_q + 4'd1 : wait_q;
  end
  always_ff @(posedge clk) begin
    state_q <= reset ? ST_IDLE : state_d;
    sel_q   <= reset ? SEL_D0B : sel_d;
    wait_q  <= reset ? 4'd0 : wait_d;
  end
  dma_beat_counter u_cnt (
    .clk    (clk),
    .reset  (reset),
    .load_i (take_dma),
    .len_i  (dma_len),
    .dec_i  (dma_gnt),
    .last_o (last)
  );
  assign cpu_gnt    = state_q == ST_CPU_OP;
  assign dma_gnt    = state_q == ST_DMA_BURST;
  assign sel_OperaB = sel_q;
  assign dma_done   = dma_gnt & last;
  assign busy       = cpu_gnt | dma_gnt;
endmodule

// File: tb/tb_alu_oper_arbiter.sv
// tb_alu_oper_arbiter: scoreboard bench with an abstract ownership model of the arbiter.
module tb_alu_oper_arbiter;
  localparam int         LIMIT = 4;
  localparam logic [1:0] DSEL  = 2'b10;
  logic       clk = 0, reset = 1, cpu_req = 0, dma_req = 0;
  logic [1:0] cpu_sel = 0;
  logic [7:0] dma_len = 0;
  logic       cpu_gnt, dma_gnt, dma_done, busy;
  logic [1:0] sel_OperaB;
  int n_tests = 0, n_fail = 0;
  logic [5:0] exp_q[$];
  int  m_beats = 0, m_lost = 0;
  bit  m_cpu = 0;
  logic [1:0] m_sel = 0;
  always #5 clk = ~clk;
  alu_oper_arbiter #(.STARVE_LIMIT(LIMIT), .DMA_SEL(DSEL)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_sel(cpu_sel),
    .dma_req(dma_req), .dma_len(dma_len), .cpu_gnt(cpu_gnt), .dma_gnt(dma_gnt),
    .sel_OperaB(sel_OperaB), .dma_done(dma_done), .busy(busy)
  );
  task automatic drive(input bit r, input bit cr, input logic [1:0] cs, input bit dr, input logic [7:0] dl);
    bit dma_wins;
    @(posedge clk);
    #1;
    exp_q.push_back({m_cpu, m_beats > 0, m_sel, m_beats == 1, m_cpu || m_beats > 0});
    reset = r; cpu_req = cr; cpu_sel = cs; dma_req = dr; dma_len = dl;
    if (r) begin
      m_beats = 0; m_lost = 0; m_cpu = 0; m_sel = 2'b00;
    end else if (m_beats > 1) begin
      m_beats--; m_cpu = 0; m_sel = DSEL; m_lost = dr ? m_lost : 0;
    end else begin
      dma_wins = dr && (!cr || m_lost == LIMIT);
      if (dma_wins) begin
        m_beats = (dl == 0) ? 1 : int'(dl); m_cpu = 0; m_sel = DSEL; m_lost = 0;
      end else begin
        m_beats = 0; m_cpu = cr; m_sel = cr ? cs : 2'b00;
        m_lost = !dr ? 0 : (m_lost < LIMIT ? m_lost + 1 : LIMIT);
      end
    end
  endtask
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [5:0] e, a;
      e = exp_q.pop_front();
      a = {cpu_gnt, dma_gnt, sel_OperaB, dma_done, busy};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs t=%0t {cpu_gnt,dma_gnt,sel,done,busy} got %b expected %b", $time, a, e);
      end
      n_tests++;
      if ((cpu_gnt & dma_gnt) !== 1'b0) begin
        n_fail++;
        $display("FAIL exclusive t=%0t cpu_gnt=%b dma_gnt=%b expected not both", $time, cpu_gnt, dma_gnt);
      end
    end
  end
  initial begin
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 1, 2'b01, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 3);
    repeat (5) drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    repeat (3) drive(0, 0, 0, 0, 0);
    repeat (26) drive(0, 1, 2'b11, 1, 2);
    repeat (3) drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 5);
    drive(0, 0, 0, 0, 9);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 1);
    repeat (2) drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 4);
    drive(0, 0, 0, 0, 0);
    repeat (4) drive(0, 1, 2'b01, 1, 7);
    repeat (3) drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 800; i++)
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 1), 2'($urandom),
            $urandom_range(0, 9) < 4, 8'($urandom_range(0, 6)));
    repeat (3) drive(0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_oper_arbiter.md
ALU_OPER_ARBITER -- requirements
Module: alu_oper_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, number of cycles DMA may wait while losing to CPU before it wins arbitration (range 1..15).
REQ-002 Parameter DMA_SEL, default 2'b10, operand-B source driven during DMA beats (ZImm, address increment).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cpu_req  input  1  CPU requests one ALU operation; held high until cpu_gnt.
REQ-006 cpu_sel  input  2  operand-B source for CPU op (00 D0B, 01 SImm, 10 ZImm, 11 Desplazado).
REQ-007 dma_req  input  1  DMA requests a burst; held high until first dma_gnt.
REQ-008 dma_len  input  8  burst beat count, sampled on the grant-start cycle; 0 means 1 beat.
REQ-009 cpu_gnt  output  1  registered; CPU owns operand-B path this cycle.
REQ-010 dma_gnt  output  1  registered; DMA owns operand-B path this cycle.
REQ-011 sel_OperaB  output  2  registered select for the operand-B multiplexer.
REQ-012 dma_done  output  1  registered one-cycle pulse coincident with last DMA beat.
REQ-013 busy  output  1  high whenever cpu_gnt or dma_gnt is high.

Function
REQ-014 States IDLE, CPU_OP, DMA_BURST; arbitration evaluated in IDLE, CPU_OP, and the last beat of DMA_BURST.
REQ-015 Request sampled in cycle N yields grant in cycle N+1; no idle bubble between consecutive grants.
REQ-016 CPU_OP lasts exactly one cycle; cpu_gnt pulses one cycle; sel_OperaB = cpu_sel registered from cycle N.
REQ-017 Continuous cpu_req yields cpu_gnt every cycle while CPU wins arbitration.
REQ-018 Both requesting: CPU wins unless wait counter == STARVE_LIMIT, then DMA wins.
REQ-019 Wait counter (4 bits) increments each cycle dma_req high and dma_gnt low, saturates at STARVE_LIMIT, clears when DMA burst starts or dma_req low.
REQ-020 DMA_BURST holds dma_gnt for max(dma_len,1) consecutive cycles; sel_OperaB = DMA_SEL throughout; non-preemptible.
REQ-021 Beat counter loads max(dma_len,1) at burst start, decrements per beat; dma_done high when counter == 1 with dma_gnt.
REQ-022 dma_req/dma_len changes during a burst are ignored; new burst requires dma_req high at last beat or later.
REQ-023 dma_req dropped before grant withdraws request; no grant issued.
REQ-024 cpu_gnt and dma_gnt never high in same cycle.
REQ-025 No grant: sel_OperaB = 2'b00 (D0B), busy low.

Reset
REQ-026 reset high at any edge: state IDLE, cpu_gnt=0, dma_gnt=0, dma_done=0, busy=0, sel_OperaB=2'b00, wait and beat counters 0.
REQ-027 Reset mid-burst aborts burst without dma_done; requests seen after reset deasserts arbitrate normally one cycle later.

Structure
REQ-028 Shared package holds state encoding and operand-B select constants SEL_D0B, SEL_SIMM, SEL_ZIMM, SEL_DESPL.
REQ-029 One sub-module, dma_beat_counter: loadable 8-bit down-counter with last-beat flag.

Verification
REQ-030 cpu_req=1,cpu_sel=01 one cycle from IDLE -> next cycle cpu_gnt=1,sel_OperaB=01, then IDLE,sel_OperaB=00.
REQ-031 dma_req=1,dma_len=3 alone -> dma_gnt high 3 cycles,sel_OperaB=10, dma_done on 3rd beat only.
REQ-032 cpu_req and dma_req held high continuously, STARVE_LIMIT=4,dma_len=2 -> 4 cpu_gnt, 2 dma_gnt, repeating; never overlapping.
REQ-033 dma_len=0 -> exactly 1 dma_gnt cycle with dma_done.
REQ-034 reset asserted on 2nd beat of dma_len=5 burst -> next cycle all outputs 0, no dma_done.
REQ-035 cpu_req raised during burst of dma_len=4 -> cpu_gnt in cycle right after last beat.
